// File: rtl/color_pkg.sv
// Shared colour datapath types, used by the r/g/b serializer and by color_gather.
package color_pkg;

  localparam int COLOR_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } t_color;

endpackage

// File: rtl/color_gather.sv
// Deserializer: collects DN r/g/b beats into a frame and hands it downstream with
// valid/ready. The assembly buffer and output register let the next frame fill while one waits.
module color_gather
  import color_pkg::*;
#(
  parameter int DN = 4,
  localparam int CW = (DN > 1) ? $clog2(DN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  output logic          out_vld,
  input  logic          out_rdy,
  output t_color        color [DN-1:0],
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(DN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_vld_q, out_vld_d;
  t_color        color_q [DN-1:0];
  t_color        color_d [DN-1:0];
  t_color        load_frame [DN-1:0];
  t_color        beat;
  logic          is_last;
  logic          beat_fire;
  logic          frame_fire;

  assign beat       = {r, g, b};
  assign is_last    = (cnt_q == LAST);
  assign in_rdy     = !abort && !(is_last && out_vld_q && !out_rdy);
  assign beat_fire  = in_vld && in_rdy;
  assign frame_fire = out_vld_q && out_rdy;

  assign load_frame[DN-1] = beat;

  // With DN=1 every beat is the last one, so there is nothing to buffer.
  generate
    if (DN > 1) begin : g_asm
      t_color asm_q [DN-2:0];
      t_color asm_d [DN-2:0];
      logic   asm_wr;

      assign asm_wr = beat_fire && !is_last;

      always_comb begin
        for (int j = 0; j < DN - 1; j++) begin
          asm_d[j] = asm_q[j];
          if (asm_wr && (cnt_q == CW'(j))) begin
            asm_d[j] = beat;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DN - 1; j++) begin
            asm_q[j] <= '0;
          end
        end else begin
          asm_q <= asm_d;
        end
      end

      for (genvar j = 0; j < DN - 1; j++) begin : g_tap
        assign load_frame[j] = asm_q[j];
      end
    end
  endgenerate

  // A last beat arriving while the frame drains reloads the register and keeps out_vld high.
  always_comb begin
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q;
    color_d   = color_q;
    if (frame_fire) begin
      out_vld_d = 1'b0;
    end
    if (abort) begin
      cnt_d = '0;
    end else if (beat_fire) begin
      if (is_last) begin
        color_d   = load_frame;
        out_vld_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      for (int j = 0; j < DN; j++) begin
        color_q[j] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      color_q   <= color_d;
    end
  end

  assign out_vld = out_vld_q;
  assign cnt     = cnt_q;
  assign color   = color_q;

endmodule

// File: tb/tb_color_gather.sv
// Scoreboard bench for color_gather: instances with DN=4, DN=1 and DN=3 checked every
// cycle against a queue-based model of beats, frames and the held output.
module tb_color_gather;
  import color_pkg::*;

  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [NU];
  logic       abort_s [NU];
  logic       in_vld  [NU];
  logic       in_rdy  [NU];
  logic       out_vld [NU];
  logic       out_rdy [NU];
  logic [7:0] r_s     [NU];
  logic [7:0] g_s     [NU];
  logic [7:0] b_s     [NU];

  t_color     color0 [3:0];
  t_color     color1 [0:0];
  t_color     color2 [2:0];
  logic [1:0] cnt0;
  logic       cnt1;
  logic [1:0] cnt2;

  color_gather #(.DN(4)) dut0 (
    .clk(clk), .rst(rst[0]), .abort(abort_s[0]), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
    .r(r_s[0]), .g(g_s[0]), .b(b_s[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]),
    .color(color0), .cnt(cnt0)
  );

  color_gather #(.DN(1)) dut1 (
    .clk(clk), .rst(rst[1]), .abort(abort_s[1]), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
    .r(r_s[1]), .g(g_s[1]), .b(b_s[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]),
    .color(color1), .cnt(cnt1)
  );

  color_gather #(.DN(3)) dut2 (
    .clk(clk), .rst(rst[2]), .abort(abort_s[2]), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]),
    .r(r_s[2]), .g(g_s[2]), .b(b_s[2]), .out_vld(out_vld[2]), .out_rdy(out_rdy[2]),
    .color(color2), .cnt(cnt2)
  );

  t_color obs     [NU][4];
  int     obs_cnt [NU];

  always_comb begin
    for (int u = 0; u < NU; u++) begin
      for (int j = 0; j < 4; j++) begin
        obs[u][j] = '0;
      end
    end
    for (int j = 0; j < 4; j++) obs[0][j] = color0[j];
    obs[1][0] = color1[0];
    for (int j = 0; j < 3; j++) obs[2][j] = color2[j];
    obs_cnt[0] = int'(cnt0);
    obs_cnt[1] = int'(cnt1);
    obs_cnt[2] = int'(cnt2);
  end

  // Model: beats of the frame in progress, completed frames not yet taken, last frame taken.
  t_color part_q [NU][$];
  t_color exp_q  [NU][$];
  t_color held   [NU][4];
  bit     started   [NU];
  int     accepted  [NU];
  int     delivered [NU];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int dnOf(input int u);
    case (u)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int u, input logic [31:0] act,
                             input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s unit%0d: got %h, want %h at %0t", name, u, act, expv, $time);
    end
  endtask

  task automatic monitorUnit(input int u);
    int     dn;
    bit     pend;
    bit     mdl_rdy;
    t_color shown;
    dn   = dnOf(u);
    pend = (exp_q[u].size() != 0);
    mdl_rdy = !abort_s[u] && !((part_q[u].size() == dn - 1) && pend && !out_rdy[u]);
    if (started[u]) begin
      checkOutput("out_vld", u, 32'(out_vld[u]), 32'(pend));
      checkOutput("cnt", u, obs_cnt[u], part_q[u].size());
      checkOutput("in_rdy", u, 32'(in_rdy[u]), 32'(mdl_rdy));
      for (int j = 0; j < dn; j++) begin
        shown = pend ? exp_q[u][j] : held[u][j];
        checkOutput($sformatf("color[%0d]", j), u, 32'(obs[u][j]), 32'(shown));
      end
    end
    if (rst[u]) begin
      part_q[u].delete();
      exp_q[u].delete();
      for (int j = 0; j < 4; j++) held[u][j] = '0;
      started[u] = 1'b1;
    end else if (started[u]) begin
      if (pend && out_rdy[u]) begin
        for (int j = 0; j < dn; j++) held[u][j] = exp_q[u].pop_front();
        delivered[u]++;
      end
      if (abort_s[u]) begin
        part_q[u].delete();
      end else if (in_vld[u] && mdl_rdy) begin
        part_q[u].push_back({r_s[u], g_s[u], b_s[u]});
        accepted[u]++;
        if (part_q[u].size() == dn) begin
          for (int j = 0; j < dn; j++) exp_q[u].push_back(part_q[u][j]);
          part_q[u].delete();
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) monitorUnit(u);
  end

  task automatic applyStimulus(input int u, input logic vld, input logic [7:0] rr,
                               input logic [7:0] gg, input logic [7:0] bb,
                               input logic ordy, input logic ab, input logic rs);
    in_vld[u]  = vld;
    r_s[u]     = rr;
    g_s[u]     = gg;
    b_s[u]     = bb;
    out_rdy[u] = ordy;
    abort_s[u] = ab;
    rst[u]     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input int u, input logic [7:0] k, input logic ordy);
    applyStimulus(u, 1'b1, k, k, k, ordy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) applyStimulus(u, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  int base;
  int cyc;

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; abort_s[u] = 1'b0; in_vld[u] = 1'b0; out_rdy[u] = 1'b1;
      r_s[u] = '0; g_s[u] = '0; b_s[u] = '0;
      started[u] = 1'b0; accepted[u] = 0; delivered[u] = 0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_out_vld", 0, 32'(out_vld[0]), 32'd0);
    checkOutput("reset_cnt", 0, obs_cnt[0], 0);
    checkOutput("reset_color0", 0, 32'(obs[0][0]), 32'h0);
    for (int u = 0; u < NU; u++) rst[u] = 1'b0;

    $display("[TB] streaming 16 beats, DN=4");
    base = delivered[0];
    for (int k = 0; k < 16; k++) sendBeat(0, 8'(k), 1'b1);
    idle(0, 2);
    checkOutput("stream_frames", 0, delivered[0] - base, 4);

    $display("[TB] backpressure");
    for (int k = 0; k < 4; k++) sendBeat(0, 8'(k), 1'b1);
    for (int k = 4; k < 7; k++) sendBeat(0, 8'(k), 1'b0);
    for (int i = 0; i < 3; i++) sendBeat(0, 8'd7, 1'b0);
    checkOutput("stall_in_rdy", 0, 32'(in_rdy[0]), 32'd0);
    checkOutput("stall_cnt", 0, obs_cnt[0], 3);
    checkOutput("stall_color3", 0, 32'(obs[0][3]), 32'h030303);
    sendBeat(0, 8'd7, 1'b1);
    checkOutput("reload_out_vld", 0, 32'(out_vld[0]), 32'd1);
    checkOutput("reload_color0", 0, 32'(obs[0][0]), 32'h040404);
    checkOutput("reload_color3", 0, 32'(obs[0][3]), 32'h070707);
    idle(0, 2);

    $display("[TB] abort with partial frame");
    sendBeat(0, 8'h00, 1'b1);
    sendBeat(0, 8'h01, 1'b1);
    applyStimulus(0, 1'b1, 8'h55, 8'h55, 8'h55, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_cnt", 0, obs_cnt[0], 0);
    for (int k = 16; k < 20; k++) sendBeat(0, 8'(k), 1'b1);
    checkOutput("abort_frame0", 0, 32'(obs[0][0]), 32'h101010);
    checkOutput("abort_frame3", 0, 32'(obs[0][3]), 32'h131313);
    idle(0, 2);

    $display("[TB] reset mid-stall");
    for (int k = 0; k < 4; k++) sendBeat(0, 8'(k), 1'b1);
    for (int k = 32; k < 35; k++) sendBeat(0, 8'(k), 1'b0);
    applyStimulus(0, 1'b1, 8'h77, 8'h77, 8'h77, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_out_vld", 0, 32'(out_vld[0]), 32'd0);
    checkOutput("rst_cnt", 0, obs_cnt[0], 0);
    for (int j = 0; j < 4; j++) checkOutput("rst_color", 0, 32'(obs[0][j]), 32'h0);
    for (int k = 48; k < 56; k++) sendBeat(0, 8'(k), 1'b1);
    idle(0, 2);

    $display("[TB] DN=1 with out_rdy toggling");
    base = delivered[1];
    sendBeat(1, 8'hAA, 1'b0);
    sendBeat(1, 8'hBB, 1'b0);
    checkOutput("dn1_pending", 1, 32'(obs[1][0]), 32'hAAAAAA);
    sendBeat(1, 8'hBB, 1'b1);
    checkOutput("dn1_second", 1, 32'(obs[1][0]), 32'hBBBBBB);
    idle(1, 2);
    checkOutput("dn1_frames", 1, delivered[1] - base, 2);

    $display("[TB] random traffic, DN=3");
    cyc = 0;
    while (accepted[2] < 1000 && cyc < 20000) begin
      applyStimulus(2, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, 1'b0);
      cyc++;
    end
    checkOutput("rand_beats", 2, 32'(accepted[2] >= 1000), 32'd1);
    idle(2, 4);
    checkOutput("rand_drained", 2, exp_q[2].size(), 0);
    checkOutput("rand_frames", 2, 32'(delivered[2] > 250), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
